// File: rtl/btn_pkg.sv
// Shared types and defaults for the push-button conditioning logic.
package btn_pkg;

    // Debounce FSM: two stable states, each with a pending state that
    // must survive a full stability window before the level flips.
    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // 10 ms stability window and 1 s long-press time at 100 MHz.
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int LONG_CYCLES_DEF     = 100_000_000;

    // Counter width able to hold n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizes the raw pad, debounces it and
// emits registered level, press, release and long-press events.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

    logic          sync;
    btn_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [HW-1:0] hold, hold_nxt, hold_inc;
    logic          long_fired, long_fired_nxt;
    logic          level_nxt, press_nxt, release_nxt, long_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (sync)
    );

    // State, counters and all outputs are registered together so every
    // event lines up with the state change that caused it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RELEASED;
            cnt           <= '0;
            hold          <= '0;
            long_fired    <= 1'b0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            hold          <= hold_nxt;
            long_fired    <= long_fired_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    // Next-state logic; the hold timer keeps running through release
    // bounce so a shaky release cannot restart the long-press timer.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        hold_nxt       = hold;
        long_fired_nxt = long_fired;
        level_nxt      = btn_level;
        press_nxt      = 1'b0;
        release_nxt    = 1'b0;
        long_nxt       = 1'b0;
        hold_inc       = (hold == HOLD_LAST) ? hold : hold + 1'b1;

        if (state == PRESSED || state == RELEASE_PEND) begin
            hold_nxt = hold_inc;
            if (hold_inc == HOLD_LAST && !long_fired) begin
                long_nxt       = 1'b1;
                long_fired_nxt = 1'b1;
            end
        end

        case (state)
            RELEASED: begin
                if (sync) begin
                    state_nxt = PRESS_PEND;
                    cnt_nxt   = '0;
                end
            end
            PRESS_PEND: begin
                if (!sync) begin
                    state_nxt = RELEASED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt      = PRESSED;
                    press_nxt      = 1'b1;
                    level_nxt      = 1'b1;
                    hold_nxt       = '0;
                    long_fired_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_nxt = RELEASE_PEND;
                    cnt_nxt   = '0;
                end
            end
            RELEASE_PEND: begin
                if (sync) begin
                    state_nxt = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RELEASED;
                    release_nxt = 1'b1;
                    level_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a small debounce window and
// long-press time; expected output vectors are queued with stimulus.
module tb_btn_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 16;

    logic clk;
    logic rst;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_pulse;

    int checks = 0;
    int errors = 0;

    // Per-edge stimulus and the {level, press, release, long} vector
    // expected just after the edge that captures that stimulus.
    logic       stim_q[$];
    logic [3:0] exp_q[$];
    string      tag_q[$];

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse)
    );

    initial clk = 1'b0;

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    task automatic pushCycle(input logic b, input logic [3:0] e, input string tag);
        stim_q.push_back(b);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        logic [3:0] obs;
        logic [3:0] exp;
        string      tag;
        obs = {btn_level, press_pulse, release_pulse, long_pulse};
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %b expected %b (lvl,prs,rel,lng)", tag, obs, exp);
        end
    endtask

    // Drive one queued input per cycle and compare 1 ns after each edge.
    task automatic applyStimulus();
        while (stim_q.size() > 0) begin
            btn_in = stim_q.pop_front();
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(4'b0000);
        tag_q.push_back("reset_state");
        checkOutput();
        #2 rst = 1'b0;

        $display("[TB] clean press held into long press");
        for (int i = 0; i < 40; i++)
            pushCycle(1'b1, {(i >= 6), (i == 6), 1'b0, (i == 21)}, $sformatf("long_press e%0d", i));
        applyStimulus();

        $display("[TB] release with a two-cycle glitch");
        for (int j = 0; j < 20; j++)
            pushCycle((j >= 2 && j < 6) ? 1'b1 : 1'b0,
                      {(j < 12), 1'b0, (j == 12), 1'b0}, $sformatf("release_bounce e%0d", j));
        applyStimulus();

        $display("[TB] bounce rejected");
        for (int k = 0; k < 20; k++)
            pushCycle((k < 8) ? ~k[1] : 1'b0, 4'b0000, $sformatf("bounce e%0d", k));
        applyStimulus();

        $display("[TB] short press");
        for (int i = 0; i < 24; i++)
            pushCycle((i < 8) ? 1'b1 : 1'b0,
                      {(i >= 6 && i < 14), (i == 6), (i == 14), 1'b0}, $sformatf("short_press e%0d", i));
        applyStimulus();

        $display("[TB] reset while press pending");
        for (int i = 0; i < 4; i++)
            pushCycle(1'b1, 4'b0000, $sformatf("pend e%0d", i));
        applyStimulus();
        #2 rst = 1'b1;
        #1;
        exp_q.push_back(4'b0000);
        tag_q.push_back("rst_pend_async");
        checkOutput();
        @(posedge clk);
        #1;
        exp_q.push_back(4'b0000);
        tag_q.push_back("rst_pend_held");
        checkOutput();
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++)
            pushCycle(1'b1, {(i >= 6), (i == 6), 1'b0, 1'b0}, $sformatf("repress e%0d", i));
        applyStimulus();

        $display("[TB] reset while pressed");
        #2 rst = 1'b1;
        btn_in = 1'b0;
        #1;
        exp_q.push_back(4'b0000);
        tag_q.push_back("rst_pressed_async");
        checkOutput();
        @(posedge clk);
        #1;
        exp_q.push_back(4'b0000);
        tag_q.push_back("rst_pressed_held");
        checkOutput();
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++)
            pushCycle(1'b0, 4'b0000, $sformatf("after_rst e%0d", i));
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and conditions a raw Basys3 push-button into clean, glitch-free control events. It sits directly upstream of the LED blink logic and supplies the press, release and long-press events that gate or retime it. Input path: 2-flop synchronizer, then a 4-state debounce FSM with a stability counter and a hold timer. All outputs are registered.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles the input must stay stable before a level change is accepted (10 ms at 100 MHz). Must be ≥ 1.
- `LONG_CYCLES`, default 100_000_000: cycles of accepted press before `long_pulse` fires (1 s). Must be > `DEBOUNCE_CYCLES`.
- `clk`, input, 1: system clock, 100 MHz.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `btn_in`, input, 1: raw pad, asynchronous to `clk`, bouncy.
- `btn_level`, output, 1: debounced button level.
- `press_pulse`, output, 1: one-cycle strobe on an accepted press.
- `release_pulse`, output, 1: one-cycle strobe on an accepted release.
- `long_pulse`, output, 1: one-cycle strobe, at most once per press.

## Operation
- **Synchronizer.** `btn_in` passes through 2 flops to produce `sync`. Both flops reset to 0.
- **Counters.**
  - Stability counter `cnt`: width `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
  - Hold counter `hold`: width `$clog2(LONG_CYCLES)`, saturating.
- **FSM states and transitions:**
  - RELEASED:
    - `sync`=1: go to PRESS_PEND, `cnt`←0.
  - PRESS_PEND:
    - `sync`=0: return to RELEASED (bounce rejected, no output).
    - `cnt`==`DEBOUNCE_CYCLES`-1 and `sync`=1: go to PRESSED, pulse `press_pulse`, `btn_level`←1, `hold`←0, clear the long-fired flag.
    - Otherwise: `cnt`++.
  - PRESSED:
    - `hold` increments and saturates at `LONG_CYCLES`-1.
    - When `hold` reaches `LONG_CYCLES`-1 and the long-fired flag is clear: pulse `long_pulse`, set the flag.
    - `sync`=0: go to RELEASE_PEND, `cnt`←0.
  - RELEASE_PEND:
    - `hold` keeps counting, so release bounce does not restart the long-press timer.
    - `sync`=1: return to PRESSED.
    - `cnt`==`DEBOUNCE_CYCLES`-1 and `sync`=0: go to RELEASED, pulse `release_pulse`, `btn_level`←0.
    - Otherwise: `cnt`++.
    - `long_pulse` may fire in this state if `hold` reaches `LONG_CYCLES`-1 here.
- **Simultaneous events.** If `long_pulse` and `release_pulse` fall on the same edge, both assert.
- **Mutual exclusion.** `press_pulse` and `release_pulse` never assert in the same cycle.
- **Reset values.** All outputs are 0, state is RELEASED, counters are 0, flag is clear.
- **Reset mid-operation.** Pending events are dropped and no pulse is emitted. If the button is still held after reset deasserts, a fresh press is detected and `press_pulse` fires normally.

## Timing
- Let edge N be the first edge at which stable-high `btn_in` is captured:
  - `sync`=1 after edge N+1.
  - PRESS_PEND entered at edge N+2.
  - `press_pulse` and `btn_level` rise at edge N+2+`DEBOUNCE_CYCLES`.
  - `press_pulse` is high for exactly one cycle.
- `long_pulse` rises at edge N+2+`DEBOUNCE_CYCLES`+`LONG_CYCLES`-1, provided the button has not been released by then.
- Release is symmetric: `release_pulse` rises, and `btn_level` falls, at edge M+2+`DEBOUNCE_CYCLES`, where M is the first edge capturing stable-low input.
- Any input glitch shorter than `DEBOUNCE_CYCLES` cycles is invisible at the outputs.

## Structure
- **Package `btn_pkg`:**
  - State enum type `btn_state_t` with RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - Default constants `DEBOUNCE_CYCLES_DEF` and `LONG_CYCLES_DEF`.
- **Sub-module `sync_2ff`:** 1-bit, with `clk` and `rst`, reused for switches elsewhere on the board.
- **Top.** FSM, both counters and the registered outputs live in `btn_debounce`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_CYCLES`=16.
- **Clean press.** Set `btn_in` to 1 at edge 0 → `press_pulse`=1 only in the cycle after edge 6; `btn_level`=1 from edge 6 onward.
- **Bounce rejected.** Toggle `btn_in` 1,0,1,0 with 2-cycle periods, then hold 0 → no pulse on any output; `btn_level` stays 0.
- **Long press.** Hold 1 for 40 cycles → exactly one `long_pulse` at edge 21. No second pulse.
- **Release with bounce.** From PRESSED, give a 2-cycle low glitch, then a stable low at edge M → no `release_pulse` for the glitch; `release_pulse` at edge M+6.
- **Reset mid-press.** Assert `rst` asynchronously while in PRESS_PEND with the input still high:
  - Outputs go to 0 immediately.
  - After `rst` deasserts, `press_pulse` fires 6 edges after the first capture.
- **Short press.** Press held for 8 cycles → `press_pulse` then `release_pulse`, and no `long_pulse`.
